waveform_meter: RTL and testbench
=================================

Name: waveform_meter

Overview:
- Downstream measurement stage for the two-output timing generator (f, g).
- Samples both waveforms and measures, per channel, the high-pulse width and the rising-edge-to-rising-edge period.
- Also measures the f&g overlap per f period and flags stuck or saturated channels.
- Results feed status/display logic and self-check benches.

Parameters:
- CNT_W, 12, width of every measurement counter and result port; counters saturate at 2^CNT_W-1.
- TIMEOUT, 2000, number of cycles without any edge on a channel before its stuck flag asserts.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- f  input  1  waveform f, synchronous to clock.
- g  input  1  waveform g, synchronous to clock.
- f_high_len  output  CNT_W  last captured f high width, in cycles.
- f_period  output  CNT_W  last captured f period, in cycles.
- g_high_len  output  CNT_W  last captured g high width, in cycles.
- g_period  output  CNT_W  last captured g period, in cycles.
- overlap_len  output  CNT_W  cycles with f&g high during the last complete f period.
- meas_valid  output  1  one-cycle pulse; f_period and overlap_len were updated this cycle.
- stuck_f  output  1  no f edge for TIMEOUT cycles.
- stuck_g  output  1  no g edge for TIMEOUT cycles.
- sat  output  1  sticky; some captured value saturated.

Behaviour:
- Reset (resetn low, asynchronous):
  - All outputs and internal registers go to 0.
  - Both channel FSMs go to SYNC.
  - Applies at any time, including mid-measurement; no partial result survives.
- Input stage:
  - s_x <= x each cycle; p_x <= s_x.
  - rise_x = s_x & ~p_x; fall_x = ~s_x & p_x.
  - Outputs update on the clock edge after the detecting cycle, so 2 cycles from input change.
- Channel FSM (one instance for f, one for g):
  - SYNC: wait for s_x=0, then go to WAIT_RISE. A level high at reset release is never treated as a rising edge.
  - WAIT_RISE: on rise_x, set period_cnt<=1 and high_cnt<=1, go to RUN. Nothing is captured.
  - RUN, every cycle: period_cnt increments. high_cnt increments while s_x=1 and no rise.
  - RUN, on fall_x: x_high_len <= high_cnt.
  - RUN, on rise_x: x_period <= period_cnt; period_cnt<=1; high_cnt<=1.
  - The first period and first high width are therefore published only after a complete cycle.
- Overlap (referenced to channel f):
  - overlap_acc counts cycles with s_f&s_g in the current f period.
  - On rise_f in WAIT_RISE: overlap_acc <= s_g.
  - On rise_f in RUN: overlap_len <= overlap_acc; overlap_acc <= s_g; meas_valid=1 for that one update cycle.
  - meas_valid is 0 at all other times.
- Saturation:
  - All counters hold at 2^CNT_W-1 and never wrap.
  - Any capture of a saturated value sets sat; sat clears only on reset.
- Stuck detection:
  - idle_x resets to 0 on any rise_x/fall_x and otherwise increments, saturating.
  - stuck_x=1 while idle_x >= TIMEOUT, in any FSM state. It deasserts the cycle after the next edge is registered.
- Simultaneous events:
  - f and g edges in the same cycle are handled independently.
  - rise and fall cannot coincide on one channel.
  - A 1-cycle high pulse gives high_len=1.
- Stuck channel: a channel stuck high or low keeps its last captured values.

Test Plan:
1. Drive the timing-generator pattern (901-cycle period; f low 199 cycles; g high 249 cycles, starting 100 cycles after f falls) for 3 periods -> after the 2nd f rise: f_period=901, f_high_len=702, g_period=901, g_high_len=249, overlap_len=150, one meas_valid pulse per f rise from the 2nd onward, sat=0, stuck_f=stuck_g=0.
2. f=1 at reset release for 2500 cycles -> no capture and meas_valid never pulses; stuck_f=1 from 2000 idle cycles; after f drops and rises twice 50 cycles apart (high 30 cycles), f_period=50 and f_high_len=30.
3. CNT_W=8, f period 300 with 100 high -> f_period=255, f_high_len=100, sat=1, held until reset.
4. Assert resetn low at cycle 400 of a period -> all outputs 0 immediately; after release, capture resumes only after SYNC→WAIT_RISE→RUN plus one full period.
5. g held 0, f periodic 100 -> g outputs stay 0; overlap_len=0 on every meas_valid; stuck_g=1 after 2000 cycles.
6. f and g both pulse high for 1 cycle every 10 cycles, aligned -> f_high_len=g_high_len=1, periods=10, overlap_len=1.

Source files
------------

// File: rtl/waveform_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// waveform_meter : per-channel high width / period of f and g, f&g overlap per
//                  f period, stuck-channel and sticky saturation flags.
// Revision       : 1.0  initial release
// ----------------------------------------------------------------------------
module waveform_meter #(
    parameter int CNT_W   = 12,
    parameter int TIMEOUT = 2000
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             f,
    input  logic             g,
    output logic [CNT_W-1:0] f_high_len,
    output logic [CNT_W-1:0] f_period,
    output logic [CNT_W-1:0] g_high_len,
    output logic [CNT_W-1:0] g_period,
    output logic [CNT_W-1:0] overlap_len,
    output logic             meas_valid,
    output logic             stuck_f,
    output logic             stuck_g,
    output logic             sat
);
    localparam int                IDLE_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  C_MAX      = '1;
    localparam logic [CNT_W-1:0]  C_ONE      = CNT_W'(1);
    localparam logic [IDLE_W-1:0] C_IDLE_MAX = '1;
    localparam logic [IDLE_W-1:0] C_IDLE_ONE = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] C_TIMEOUT  = IDLE_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_SYNC      = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_RUN       = 2'd2
    } state_t;

    logic [1:0]       w_in;
    logic [1:0]       w_s;
    logic [1:0]       w_stuck;
    logic [1:0]       w_sat_ev;
    logic             w_ovl_sat;
    logic [CNT_W-1:0] w_high_len [2];
    logic [CNT_W-1:0] w_period   [2];

    assign w_in = {g, f};

    for (genvar i = 0; i < 2; i++) begin : g_ch
        state_t            r_state;
        state_t            w_state_nxt;
        logic              r_primed;
        logic              r_s;
        logic              r_p;
        logic              w_rise;
        logic              w_fall;
        logic [CNT_W-1:0]  r_period_cnt;
        logic [CNT_W-1:0]  r_high_cnt;
        logic [CNT_W-1:0]  r_high_len;
        logic [CNT_W-1:0]  r_period;
        logic [IDLE_W-1:0] r_idle;

        assign w_rise        = r_s & ~r_p;
        assign w_fall        = ~r_s & r_p;
        assign w_s[i]        = r_s;
        assign w_stuck[i]    = (r_idle >= C_TIMEOUT);
        assign w_high_len[i] = r_high_len;
        assign w_period[i]   = r_period;
        assign w_sat_ev[i]   = (r_state == ST_RUN) &&
                               ((w_rise && (r_period_cnt == C_MAX)) ||
                                (w_fall && (r_high_cnt == C_MAX)));

        // r_primed keeps SYNC from trusting the reset value of the sampler,
        // so a level already high at reset release is never seen as an edge.
        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_primed <= 1'b0;
                r_s      <= 1'b0;
                r_p      <= 1'b0;
                r_state  <= ST_SYNC;
            end else begin
                r_primed <= 1'b1;
                r_s      <= w_in[i];
                r_p      <= r_s;
                r_state  <= w_state_nxt;
            end
        end

        always_comb begin
            w_state_nxt = r_state;
            case (r_state)
                ST_SYNC:      if (r_primed && !r_s) w_state_nxt = ST_WAIT_RISE;
                ST_WAIT_RISE: if (w_rise) w_state_nxt = ST_RUN;
                ST_RUN:       w_state_nxt = ST_RUN;
                default:      w_state_nxt = ST_SYNC;
            endcase
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_period_cnt <= '0;
                r_high_cnt   <= '0;
                r_high_len   <= '0;
                r_period     <= '0;
                r_idle       <= '0;
            end else begin
                if (w_rise || w_fall) begin
                    r_idle <= '0;
                end else if (r_idle != C_IDLE_MAX) begin
                    r_idle <= r_idle + C_IDLE_ONE;
                end
                case (r_state)
                    ST_WAIT_RISE: begin
                        if (w_rise) begin
                            r_period_cnt <= C_ONE;
                            r_high_cnt   <= C_ONE;
                        end
                    end
                    ST_RUN: begin
                        if (w_rise) begin
                            r_period     <= r_period_cnt;
                            r_period_cnt <= C_ONE;
                            r_high_cnt   <= C_ONE;
                        end else begin
                            if (r_period_cnt != C_MAX) r_period_cnt <= r_period_cnt + C_ONE;
                            if (r_s && (r_high_cnt != C_MAX)) r_high_cnt <= r_high_cnt + C_ONE;
                        end
                        if (w_fall) r_high_len <= r_high_cnt;
                    end
                    default: ;
                endcase
            end
        end

        if (i == 0) begin : g_ovl
            logic [CNT_W-1:0] r_overlap_acc;

            assign w_ovl_sat = (r_state == ST_RUN) && w_rise && (r_overlap_acc == C_MAX);

            // The f rising-edge cycle itself belongs to the new f period.
            always_ff @(posedge clock or negedge resetn) begin
                if (!resetn) begin
                    r_overlap_acc <= '0;
                    overlap_len   <= '0;
                    meas_valid    <= 1'b0;
                end else begin
                    meas_valid <= 1'b0;
                    if ((r_state == ST_WAIT_RISE) && w_rise) begin
                        r_overlap_acc <= CNT_W'(w_s[1]);
                    end else if (r_state == ST_RUN) begin
                        if (w_rise) begin
                            overlap_len   <= r_overlap_acc;
                            r_overlap_acc <= CNT_W'(w_s[1]);
                            meas_valid    <= 1'b1;
                        end else if (w_s[0] && w_s[1] && (r_overlap_acc != C_MAX)) begin
                            r_overlap_acc <= r_overlap_acc + C_ONE;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sat <= 1'b0;
        end else if ((|w_sat_ev) || w_ovl_sat) begin
            sat <= 1'b1;
        end
    end

    assign f_high_len = w_high_len[0];
    assign f_period   = w_period[0];
    assign g_high_len = w_high_len[1];
    assign g_period   = w_period[1];
    assign stuck_f    = w_stuck[0];
    assign stuck_g    = w_stuck[1];

endmodule
`default_nettype wire

// File: tb/tb_waveform_meter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_waveform_meter : directed + random stimulus on two parameterisations of
//                     waveform_meter, checked against a timestamp-based model.
// Revision          : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_waveform_meter;
    logic clock  = 1'b0;
    logic resetn = 1'b1;
    logic f      = 1'b0;
    logic g      = 1'b0;

    always #5 clock = ~clock;

    logic [11:0] a_fhl, a_fp, a_ghl, a_gp, a_ov;
    logic        a_mv, a_sf, a_sg, a_sat;
    logic [7:0]  b_fhl, b_fp, b_ghl, b_gp, b_ov;
    logic        b_mv, b_sf, b_sg, b_sat;

    waveform_meter #(.CNT_W(12), .TIMEOUT(2000)) u_dut0 (
        .clock(clock), .resetn(resetn), .f(f), .g(g),
        .f_high_len(a_fhl), .f_period(a_fp), .g_high_len(a_ghl), .g_period(a_gp),
        .overlap_len(a_ov), .meas_valid(a_mv), .stuck_f(a_sf), .stuck_g(a_sg), .sat(a_sat)
    );

    waveform_meter #(.CNT_W(8), .TIMEOUT(300)) u_dut1 (
        .clock(clock), .resetn(resetn), .f(f), .g(g),
        .f_high_len(b_fhl), .f_period(b_fp), .g_high_len(b_ghl), .g_period(b_gp),
        .overlap_len(b_ov), .meas_valid(b_mv), .stuck_f(b_sf), .stuck_g(b_sg), .sat(b_sat)
    );

    int n_total = 0;
    int n_bad   = 0;
    int n_mv    = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: index [d] = DUT instance, [c] = channel (0=f, 1=g).
    // Widths/periods are differences of rising/falling sample timestamps.
    int m_max [2] = '{4095, 255};
    int m_to  [2] = '{2000, 300};
    int m_st   [2][2];
    int m_last [2][2];
    int m_high [2][2];
    int m_per  [2][2];
    int m_idle [2][2];
    int m_ovl_acc [2];
    int m_ovl_len [2];
    bit m_mv  [2];
    bit m_sat [2];
    bit m_prev [2];
    bit m_primed;
    int m_now;

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic mdl_sample(input bit xf, input bit xg);
        bit x [2];
        bit rise;
        bit fall;
        int span;
        x[0] = xf;
        x[1] = xg;
        for (int d = 0; d < 2; d++) m_mv[d] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            rise = x[c] && !m_prev[c];
            fall = !x[c] && m_prev[c];
            for (int d = 0; d < 2; d++) begin
                if (rise || fall) m_idle[d][c] = 0;
                else if (m_idle[d][c] < 100000) m_idle[d][c]++;
                span = m_now - m_last[d][c];
                case (m_st[d][c])
                    0: if (m_primed && !x[c]) m_st[d][c] = 1;
                    1: if (rise) begin
                        m_st[d][c]   = 2;
                        m_last[d][c] = m_now;
                        if (c == 0) m_ovl_acc[d] = int'(xg);
                    end
                    default: begin
                        if (fall) begin
                            m_high[d][c] = clip(span, m_max[d]);
                            if (span >= m_max[d]) m_sat[d] = 1'b1;
                        end
                        if (rise) begin
                            m_per[d][c]  = clip(span, m_max[d]);
                            if (span >= m_max[d]) m_sat[d] = 1'b1;
                            m_last[d][c] = m_now;
                            if (c == 0) begin
                                m_ovl_len[d] = clip(m_ovl_acc[d], m_max[d]);
                                if (m_ovl_acc[d] >= m_max[d]) m_sat[d] = 1'b1;
                                m_mv[d]      = 1'b1;
                                m_ovl_acc[d] = int'(xg);
                            end
                        end else if (c == 0 && xf && xg) begin
                            m_ovl_acc[d]++;
                        end
                    end
                endcase
            end
        end
        m_prev[0] = xf;
        m_prev[1] = xg;
        m_primed  = 1'b1;
        m_now++;
    endtask

    task automatic mdl_reset();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                m_st[d][c] = 0; m_last[d][c] = 0; m_high[d][c] = 0;
                m_per[d][c] = 0; m_idle[d][c] = 0;
            end
            m_ovl_acc[d] = 0; m_ovl_len[d] = 0; m_mv[d] = 1'b0; m_sat[d] = 1'b0;
        end
        m_prev[0] = 1'b0;
        m_prev[1] = 1'b0;
        m_primed  = 1'b0;
        m_now     = 0;
        // First clock after release only sees the cleared sampler.
        mdl_sample(1'b0, 1'b0);
    endtask

    task automatic cmp_all();
        check_val("d0_f_high_len", 32'(a_fhl), m_high[0][0]);
        check_val("d0_f_period",   32'(a_fp),  m_per[0][0]);
        check_val("d0_g_high_len", 32'(a_ghl), m_high[0][1]);
        check_val("d0_g_period",   32'(a_gp),  m_per[0][1]);
        check_val("d0_overlap",    32'(a_ov),  m_ovl_len[0]);
        check_val("d0_meas_valid", 32'(a_mv),  32'(m_mv[0]));
        check_val("d0_stuck_f",    32'(a_sf),  32'(m_idle[0][0] >= m_to[0]));
        check_val("d0_stuck_g",    32'(a_sg),  32'(m_idle[0][1] >= m_to[0]));
        check_val("d0_sat",        32'(a_sat), 32'(m_sat[0]));
        check_val("d1_f_high_len", 32'(b_fhl), m_high[1][0]);
        check_val("d1_f_period",   32'(b_fp),  m_per[1][0]);
        check_val("d1_g_high_len", 32'(b_ghl), m_high[1][1]);
        check_val("d1_g_period",   32'(b_gp),  m_per[1][1]);
        check_val("d1_overlap",    32'(b_ov),  m_ovl_len[1]);
        check_val("d1_meas_valid", 32'(b_mv),  32'(m_mv[1]));
        check_val("d1_stuck_f",    32'(b_sf),  32'(m_idle[1][0] >= m_to[1]));
        check_val("d1_stuck_g",    32'(b_sg),  32'(m_idle[1][1] >= m_to[1]));
        check_val("d1_sat",        32'(b_sat), 32'(m_sat[1]));
    endtask

    // Called at a falling edge: drive the next sample, let it be clocked in,
    // then compare outputs (which reflect the previous sample) and update the model.
    task automatic tick(input bit nf, input bit ng);
        f = nf;
        g = ng;
        @(posedge clock);
        @(negedge clock);
        cmp_all();
        if (a_mv) n_mv++;
        mdl_sample(nf, ng);
    endtask

    task automatic do_reset();
        #2 resetn = 1'b0;
        #1;
        check_val("rst_d0_values", 32'(a_fhl | a_fp | a_ghl | a_gp | a_ov), 0);
        check_val("rst_d0_flags",  32'({a_mv, a_sf, a_sg, a_sat}), 0);
        check_val("rst_d1_values", 32'(b_fhl | b_fp | b_ghl | b_gp | b_ov), 0);
        check_val("rst_d1_flags",  32'({b_mv, b_sf, b_sg, b_sat}), 0);
        mdl_reset();
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    task automatic run_tg(input int ncyc, input int off);
        for (int k = 0; k < ncyc; k++) begin
            int o;
            o = (off + k) % 901;
            tick(o < 702, (o < 150) || (o >= 802));
        end
    endtask

    task automatic run_pg(input int ncyc, input int fper, input int fhi,
                          input int gper, input int ghi, input int off);
        for (int k = 0; k < ncyc; k++) begin
            tick(((off + k) % fper) < fhi, ((off + k) % gper) < ghi);
        end
    endtask

    function automatic int pick_len();
        return ($urandom_range(0, 19) == 0) ? int'($urandom_range(310, 420))
                                            : int'($urandom_range(1, 40));
    endfunction

    task automatic run_rand(input int ncyc);
        int rf;
        int rg;
        bit xf;
        bit xg;
        rf = pick_len(); rg = pick_len(); xf = 1'b0; xg = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (rf == 0) begin xf = ~xf; rf = pick_len(); end
            if (rg == 0) begin xg = ~xg; rg = pick_len(); end
            rf--; rg--;
            tick(xf, xg);
        end
    endtask

    initial begin
        // Timing-generator pattern, starting with f low.
        do_reset();
        n_mv = 0;
        run_tg(2703, 702);
        check_val("tg_f_period",   32'(a_fp),  901);
        check_val("tg_f_high_len", 32'(a_fhl), 702);
        check_val("tg_g_period",   32'(a_gp),  901);
        check_val("tg_g_high_len", 32'(a_ghl), 249);
        check_val("tg_overlap",    32'(a_ov),  150);
        check_val("tg_flags",      32'({a_sat, a_sf, a_sg}), 0);
        check_val("tg_mv_pulses",  n_mv, 2);

        // f high at reset release, then two short periods.
        do_reset();
        n_mv = 0;
        repeat (2500) tick(1'b1, 1'b0);
        check_val("hi_stuck_f",    32'(a_sf),  1);
        check_val("hi_mv_pulses",  n_mv, 0);
        check_val("hi_f_period",   32'(a_fp),  0);
        repeat (20) tick(1'b0, 1'b0);
        repeat (30) tick(1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b0);
        repeat (30) tick(1'b1, 1'b0);
        repeat (5)  tick(1'b0, 1'b0);
        check_val("hi_f_period2",  32'(a_fp),  50);
        check_val("hi_f_high2",    32'(a_fhl), 30);
        check_val("hi_stuck_f_clr", 32'(a_sf), 0);

        // Saturation on the 8-bit instance, sticky without reset.
        do_reset();
        run_pg(1200, 300, 100, 1, 0, 100);
        check_val("sat_d1_f_period", 32'(b_fp),  255);
        check_val("sat_d1_f_high",   32'(b_fhl), 100);
        check_val("sat_d1_sat",      32'(b_sat), 1);
        check_val("sat_d0_f_period", 32'(a_fp),  300);
        run_pg(300, 50, 25, 50, 10, 0);
        check_val("sat_d1_held",     32'(b_sat), 1);

        // Reset in the middle of a period, then restart.
        do_reset();
        run_tg(1500, 702);
        do_reset();
        n_mv = 0;
        run_tg(2000, 400);
        check_val("mid_mv_pulses", n_mv, 1);
        check_val("mid_f_period",  32'(a_fp), 901);

        // g held low.
        do_reset();
        n_mv = 0;
        run_pg(2100, 100, 50, 1, 0, 50);
        check_val("glow_g_period", 32'(a_gp),  0);
        check_val("glow_g_high",   32'(a_ghl), 0);
        check_val("glow_overlap",  32'(a_ov),  0);
        check_val("glow_stuck_g",  32'(a_sg),  1);
        check_val("glow_mv",       n_mv, 20);

        // Aligned one-cycle pulses every 10 cycles.
        do_reset();
        run_pg(60, 10, 1, 10, 1, 1);
        check_val("pulse_f_high",   32'(a_fhl), 1);
        check_val("pulse_g_high",   32'(a_ghl), 1);
        check_val("pulse_f_period", 32'(a_fp),  10);
        check_val("pulse_g_period", 32'(a_gp),  10);
        check_val("pulse_overlap",  32'(a_ov),  1);

        // Independent random waveforms.
        do_reset();
        run_rand(3000);
        do_reset();
        run_rand(3000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
